// File: rtl/pipe_pkg.sv
// Shared constants, action encoding and WAW collapse helper
// for the parametrised pipeline boundary register.
package pipe_pkg;

   localparam logic Stop          = 1'b1;
   localparam logic NoStop        = 1'b0;
   localparam logic Write_Enable  = 1'b1;
   localparam logic Write_Disable = 1'b0;
   localparam logic [31:0] Zero_Word = 32'h0;

   localparam int MAX_LANES  = 4;
   localparam int MAX_ADDR_W = 32;

   typedef enum logic [1:0] {
      CLEAR,
      BUBBLE,
      HOLD,
      ADVANCE
   } action_e;

   // Returns per-lane enables with older-lane duplicates dropped.
   function automatic logic [MAX_LANES-1:0] collapse_mask(
      input logic [MAX_LANES-1:0]            we,
      input logic [MAX_LANES*MAX_ADDR_W-1:0] wd
   );
      logic [MAX_LANES-1:0] m;
      m = we;
      for (int i = 0; i < MAX_LANES; i++) begin
         for (int j = i + 1; j < MAX_LANES; j++) begin
            if (we[i] && we[j] &&
                wd[i*MAX_ADDR_W +: MAX_ADDR_W] ==
                wd[j*MAX_ADDR_W +: MAX_ADDR_W])
               m[i] = Write_Disable;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// 32-bit saturating event counter, cleared by rst only.
module pipe_sat_cnt
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [31:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= Zero_Word;
      else if (inc && cnt != 32'hFFFF_FFFF)
         cnt <= cnt + 32'd1;
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Multi-lane pipeline boundary register with flush, bubble, hold
// and WAW collapse; PIPE_REG_PERF_EN adds bubble/hold counters.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int LANES   = 1,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int SIDE_W  = 104,
   parameter int STALL_W = 6,
   parameter int STAGE   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [STALL_W-1:0]       stall,
   input  logic                     flush,
   input  logic [LANES-1:0]         in_we,
   input  logic [LANES*ADDR_W-1:0]  in_wd,
   input  logic [LANES*DATA_W-1:0]  in_wdata,
   input  logic [SIDE_W-1:0]        in_side,
   output logic [LANES-1:0]         out_we,
   output logic [LANES*ADDR_W-1:0]  out_wd,
   output logic [LANES*DATA_W-1:0]  out_wdata,
   output logic [SIDE_W-1:0]        out_side
`ifdef PIPE_REG_PERF_EN
  ,output logic [31:0]              bubble_cnt,
   output logic [31:0]              hold_cnt
`endif
);

   action_e act;
   logic    clr;
   logic    stop_me;
   logic    stop_nx;
   logic    unused_stall;

   logic [MAX_LANES-1:0]            we_pad;
   logic [MAX_LANES*MAX_ADDR_W-1:0] wd_pad;
   logic [MAX_LANES-1:0]            keep;
   logic [LANES-1:0]                we_nxt;

   assign clr          = rst | flush;
   assign stop_me      = stall[STAGE] == Stop;
   assign stop_nx      = stall[STAGE+1] == Stop;
   assign unused_stall = ^stall;

   always_comb begin
      act = CLEAR;
      unique case (1'b1)
         clr:                          act = CLEAR;
         !clr && stop_me && !stop_nx:  act = BUBBLE;
         !clr && stop_me && stop_nx:   act = HOLD;
         !clr && !stop_me:             act = ADVANCE;
         default:                      act = CLEAR;
      endcase
   end

   // Lanes are widened to a common shape for the package helper.
   always_comb begin
      we_pad = '0;
      wd_pad = '0;
      for (int i = 0; i < LANES; i++) begin
         we_pad[i] = in_we[i];
         wd_pad[i*MAX_ADDR_W +: MAX_ADDR_W] =
            MAX_ADDR_W'(in_wd[i*ADDR_W +: ADDR_W]);
      end
      keep   = collapse_mask(we_pad, wd_pad);
      we_nxt = LANES'(keep);
   end

   always_ff @(posedge clk) begin
      unique case (act)
         CLEAR, BUBBLE: begin
            out_we    <= '0;
            out_wd    <= '0;
            out_wdata <= '0;
            out_side  <= '0;
         end
         HOLD: begin
            out_we    <= out_we;
            out_wd    <= out_wd;
            out_wdata <= out_wdata;
            out_side  <= out_side;
         end
         ADVANCE: begin
            out_we    <= we_nxt;
            out_wd    <= in_wd;
            out_wdata <= in_wdata;
            out_side  <= in_side;
         end
         default: begin
            out_we    <= '0;
            out_wd    <= '0;
            out_wdata <= '0;
            out_side  <= '0;
         end
      endcase
   end

`ifdef PIPE_REG_PERF_EN
   pipe_sat_cnt u_bubble_cnt (
      .clk (clk),
      .rst (rst),
      .inc (act == BUBBLE),
      .cnt (bubble_cnt)
   );

   pipe_sat_cnt u_hold_cnt (
      .clk (clk),
      .rst (rst),
      .inc (act == HOLD),
      .cnt (hold_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (LANES=2, STAGE=4);
// counter checks run only when PIPE_REG_PERF_EN is defined.
module tb_pipe_stage_reg;

   localparam int L  = 2;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int SW = 104;

   logic            clk = 1'b0;
   logic            rst;
   logic [5:0]      stall;
   logic            flush;
   logic [L-1:0]    in_we;
   logic [L*AW-1:0] in_wd;
   logic [L*DW-1:0] in_wdata;
   logic [SW-1:0]   in_side;
   logic [L-1:0]    out_we;
   logic [L*AW-1:0] out_wd;
   logic [L*DW-1:0] out_wdata;
   logic [SW-1:0]   out_side;
   logic [31:0]     bubble_cnt;
   logic [31:0]     hold_cnt;

   typedef struct packed {
      logic [L-1:0]    we;
      logic [L*AW-1:0] wd;
      logic [L*DW-1:0] wdata;
      logic [SW-1:0]   side;
      logic [31:0]     bub;
      logic [31:0]     hold;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   exp_t m;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .LANES(L), .DATA_W(DW), .ADDR_W(AW), .SIDE_W(SW),
      .STALL_W(6), .STAGE(4)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_we(in_we), .in_wd(in_wd), .in_wdata(in_wdata),
      .in_side(in_side), .out_we(out_we), .out_wd(out_wd),
      .out_wdata(out_wdata), .out_side(out_side)
`ifdef PIPE_REG_PERF_EN
     ,.bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
`endif
   );

`ifndef PIPE_REG_PERF_EN
   assign bubble_cnt = 32'h0;
   assign hold_cnt   = 32'h0;
`endif

   // Reference: what the boundary should hold after the coming edge.
   task automatic step(input logic r, input logic f,
                       input logic [5:0] st, input logic [L-1:0] we,
                       input logic [L*AW-1:0] wd,
                       input logic [L*DW-1:0] wdata,
                       input logic [SW-1:0] side);
      rst = r; flush = f; stall = st;
      in_we = we; in_wd = wd; in_wdata = wdata; in_side = side;
      if (r || f) begin
         m.we = '0; m.wd = '0; m.wdata = '0; m.side = '0;
         if (r) begin
            m.bub = 0;
            m.hold = 0;
         end
      end else if (st[4] && !st[5]) begin
         m.we = '0; m.wd = '0; m.wdata = '0; m.side = '0;
         if (m.bub != 32'hFFFF_FFFF) m.bub = m.bub + 1;
      end else if (st[4]) begin
         if (m.hold != 32'hFFFF_FFFF) m.hold = m.hold + 1;
      end else begin
         for (int i = 0; i < L; i++) begin
            logic w;
            w = we[i];
            for (int j = i + 1; j < L; j++)
               if (we[j] && wd[j*AW +: AW] == wd[i*AW +: AW])
                  w = 1'b0;
            m.we[i] = w;
         end
         m.wd = wd; m.wdata = wdata; m.side = side;
      end
      q.push_back(m);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("out_we", 128'(out_we), 128'(e.we));
            chk("out_wd", 128'(out_wd), 128'(e.wd));
            chk("out_wdata", 128'(out_wdata), 128'(e.wdata));
            chk("out_side", 128'(out_side), 128'(e.side));
`ifdef PIPE_REG_PERF_EN
            chk("bubble_cnt", 128'(bubble_cnt), 128'(e.bub));
            chk("hold_cnt", 128'(hold_cnt), 128'(e.hold));
`endif
         end
      end
   end

   localparam logic [5:0] RUN  = 6'b000000;
   localparam logic [5:0] BUB  = 6'b010000;
   localparam logic [5:0] HLD  = 6'b110000;
   localparam logic [SW-1:0] SIDE_A = {8'hA5, 96'h1234_5678_9ABC_DEF0_1122_3344};

   initial begin
      m = '0;
      rst = 1'b1; flush = 1'b0; stall = '0;
      in_we = '0; in_wd = '0; in_wdata = '0; in_side = '0;
      @(negedge clk);
      step(1, 0, RUN, 2'b11, {5'd1, 5'd2}, 64'h1, SIDE_A);
      step(1, 0, RUN, 2'b00, '0, '0, '0);
      // basic advance, lanes to 3 (lane 1) and 7 (lane 0)
      step(0, 0, RUN, 2'b11, {5'd3, 5'd7}, {32'h2222, 32'h1111}, SIDE_A);
      // bubble with live inputs
      step(0, 0, BUB, 2'b11, {5'd4, 5'd5}, {32'h3, 32'h4}, SIDE_A);
      // load then hold three edges with changing inputs
      step(0, 0, RUN, 2'b01, {5'd6, 5'd8}, {32'h0, 32'hDEAD_BEEF}, SIDE_A);
      for (int k = 0; k < 3; k++)
         step(0, 0, HLD, 2'b11, {5'd9, 5'd10}, {32'(k), 32'hF00D}, '1);
      // flush beats hold
      step(0, 1, HLD, 2'b11, {5'd9, 5'd10}, {32'h5, 32'h6}, '1);
      // WAW collapse to address 9, then to address 0
      step(0, 0, RUN, 2'b11, {5'd9, 5'd9}, {32'hBBBB, 32'hAAAA}, '0);
      step(0, 0, RUN, 2'b11, {5'd0, 5'd0}, {32'hB0, 32'hA0}, '0);
      step(0, 0, RUN, 2'b01, {5'd9, 5'd9}, {32'hB1, 32'hA1}, '0);
      // hold then release straight into advance
      step(0, 0, HLD, 2'b11, {5'd1, 5'd2}, {32'h7, 32'h8}, '0);
      step(0, 0, RUN, 2'b10, {5'd11, 5'd12}, {32'h9, 32'hA}, SIDE_A);
      // reset under hold
      step(0, 0, HLD, 2'b11, '0, '0, '0);
      step(1, 0, HLD, 2'b11, {5'd1, 5'd2}, {32'h7, 32'h8}, '1);
      for (int k = 0; k < 400; k++) begin
         logic r, f;
         r = ($urandom_range(0, 39) == 0);
         f = ($urandom_range(0, 15) == 0);
         step(r, f, 6'($urandom), 2'($urandom),
              {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
              {$urandom, $urandom},
              {$urandom, $urandom, $urandom, 8'($urandom)});
      end
`ifdef PIPE_REG_PERF_EN
      step(0, 0, RUN, 2'b11, {5'd1, 5'd2}, {32'h1, 32'h2}, '0);
      force dut.u_hold_cnt.cnt = 32'hFFFF_FFFE;
      #1;
      release dut.u_hold_cnt.cnt;
      m.hold = 32'hFFFF_FFFE;
      for (int k = 0; k < 3; k++)
         step(0, 0, HLD, 2'b00, '0, '0, '0);
`endif
      step(0, 0, RUN, 2'b00, '0, '0, '0);
      @(posedge clk);
      #2;
      n_vec++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
